// File: rtl/tv80_alu_serial_if.sv
// Start/busy/done request bundle between the CPU sequencer (master) and the serial ALU (slave).
interface tv80_alu_serial_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [7:0]       f_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] q;
  logic [7:0]       f_out;

  modport master (
    output start, op, a, b, f_in,
    input  busy, done, q, f_out
  );

  modport slave (
    input  start, op, a, b, f_in,
    output busy, done, q, f_out
  );
endinterface

// File: rtl/tv80_alu_serial.sv
// Byte-serial TV80/GB ALU: WIDTH-bit ops over one 8-bit slice, GB flag byte over the full word.
// Latency WIDTH/8 edges from the start edge to the one-cycle done pulse.
// start is ignored while busy (not queued) and accepted in the done cycle; q/f_out held between completions.
module tv80_alu_serial #(
  parameter int WIDTH  = 16,
  parameter int Flag_Z = 7,
  parameter int Flag_N = 6,
  parameter int Flag_H = 5,
  parameter int Flag_C = 4
) (
  input logic              clk,
  input logic              reset,
  tv80_alu_serial_if.slave alu
);
  localparam int N  = WIDTH / 8;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  localparam logic [3:0] OP_ADD = 4'h0, OP_ADC = 4'h1, OP_SUB = 4'h2, OP_SBC = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4, OP_XOR = 4'h5, OP_OR  = 4'h6, OP_CP  = 4'h7;
  localparam logic [3:0] OP_RLC = 4'h8, OP_RRC = 4'h9, OP_RL  = 4'hA, OP_RR  = 4'hB;
  localparam logic [3:0] OP_SLA = 4'hC, OP_SRA = 4'hD, OP_SRL = 4'hE, OP_NOP = 4'hF;

  typedef enum logic [0:0] {S_IDLE, S_RUN} state_t;

  state_t           state;
  logic [KW-1:0]    k;
  logic [3:0]       op_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [7:0]       f_r;
  logic [WIDTH-1:0] res_r;
  logic             c_r;
  logic             z_r;

  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] q_r;
  logic [7:0]       f_out_r;

  logic             is_right;
  logic             is_sub;
  logic             is_arith;
  logic [KW-1:0]    idx;
  logic [KW+2:0]    sh;
  logic [7:0]       ab;
  logic [7:0]       bb;
  logic             cin0;
  logic             cin;
  logic [8:0]       sum9;
  logic             h_bit;
  logic [7:0]       out_b;
  logic             cout;
  logic [7:0]       z_byte;
  logic             z_nx;
  logic [WIDTH-1:0] res_nx;
  logic [7:0]       fo;

  always_comb begin
    is_right = op_r inside {OP_RRC, OP_RR, OP_SRA, OP_SRL};
    is_sub   = op_r inside {OP_SUB, OP_SBC, OP_CP};
    is_arith = op_r inside {OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_CP};

    // Right shifts walk the word MSB byte first so the shifted bit flows downward.
    idx = is_right ? (K_LAST - k) : k;
    sh  = {idx, 3'b000};
    ab  = 8'(a_r >> sh);
    bb  = 8'(b_r >> sh);

    case (op_r)
      OP_ADC, OP_SBC, OP_RL, OP_RR: cin0 = f_r[Flag_C];
      OP_RLC, OP_SRA:               cin0 = a_r[WIDTH-1];
      OP_RRC:                       cin0 = a_r[0];
      default:                      cin0 = 1'b0;
    endcase
    cin = (k == '0) ? cin0 : c_r;

    sum9 = is_sub ? ({1'b0, ab} - {1'b0, bb} - {8'b0, cin})
                  : ({1'b0, ab} + {1'b0, bb} + {8'b0, cin});
    // Carry/borrow into bit 4 of this slice, recovered from the sum bit.
    h_bit = ab[4] ^ bb[4] ^ sum9[4];

    case (op_r)
      OP_ADD, OP_ADC, OP_SUB, OP_SBC: begin out_b = sum9[7:0];        cout = sum9[8]; end
      OP_CP:                          begin out_b = ab;               cout = sum9[8]; end
      OP_AND:                         begin out_b = ab & bb;          cout = 1'b0;    end
      OP_XOR:                         begin out_b = ab ^ bb;          cout = 1'b0;    end
      OP_OR:                          begin out_b = ab | bb;          cout = 1'b0;    end
      OP_RLC, OP_RL, OP_SLA:          begin out_b = {ab[6:0], cin};   cout = ab[7];   end
      OP_RRC, OP_RR, OP_SRA, OP_SRL:  begin out_b = {cin, ab[7:1]};   cout = ab[0];   end
      default:                        begin out_b = ab;               cout = 1'b0;    end
    endcase

    z_byte = (op_r == OP_CP) ? sum9[7:0] : out_b;
    z_nx   = z_r | (|z_byte);
    res_nx = (res_r & ~(WIDTH'(8'hFF) << sh)) | (WIDTH'(out_b) << sh);

    // The top byte is always the last slice for arithmetic, so h_bit there is the word's H.
    fo         = {4'b0000, f_r[3:0]};
    fo[Flag_Z] = ~z_nx;
    fo[Flag_N] = is_sub;
    fo[Flag_H] = is_arith ? h_bit : (op_r == OP_AND);
    fo[Flag_C] = cout;
    if (op_r == OP_NOP) fo = f_r;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      k       <= '0;
      op_r    <= OP_NOP;
      a_r     <= '0;
      b_r     <= '0;
      f_r     <= '0;
      res_r   <= '0;
      c_r     <= 1'b0;
      z_r     <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      q_r     <= '0;
      f_out_r <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (alu.start) begin
            op_r   <= alu.op;
            a_r    <= alu.a;
            b_r    <= alu.b;
            f_r    <= alu.f_in;
            k      <= '0;
            z_r    <= 1'b0;
            busy_r <= 1'b1;
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          res_r <= res_nx;
          z_r   <= z_nx;
          c_r   <= cout;
          if (k == K_LAST) begin
            q_r     <= res_nx;
            f_out_r <= fo;
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
            state   <= S_IDLE;
          end else begin
            k <= k + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign alu.busy  = busy_r;
  assign alu.done  = done_r;
  assign alu.q     = q_r;
  assign alu.f_out = f_out_r;
endmodule

// File: tb/tb_tv80_alu_serial.sv
// Directed bench for tv80_alu_serial at WIDTH=16 and WIDTH=32: vector table plus handshake/reset sequences.
module tb_tv80_alu_serial;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  tv80_alu_serial_if #(.WIDTH(16)) if16 ();
  tv80_alu_serial_if #(.WIDTH(32)) if32 ();

  tv80_alu_serial #(.WIDTH(16)) dut16 (.clk(clk), .reset(reset), .alu(if16));
  tv80_alu_serial #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .alu(if32));

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          w32;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [7:0]  f;
    logic [31:0] q;
    logic [7:0]  fo;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input bit w, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic [7:0] f, input logic [31:0] q, input logic [7:0] fo);
    vec_t v;
    v.w32 = w; v.op = op; v.a = a; v.b = b; v.f = f; v.q = q; v.fo = fo;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit w32, input logic st, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [7:0] f);
    if (w32) begin
      if32.start = st; if32.op = op; if32.a = a; if32.b = b; if32.f_in = f;
    end else begin
      if16.start = st; if16.op = op; if16.a = a[15:0]; if16.b = b[15:0]; if16.f_in = f;
    end
  endtask

  function automatic logic get_done(input bit w32);
    return w32 ? if32.done : if16.done;
  endfunction
  function automatic logic get_busy(input bit w32);
    return w32 ? if32.busy : if16.busy;
  endfunction
  function automatic logic [31:0] get_q(input bit w32);
    return w32 ? if32.q : {16'h0000, if16.q};
  endfunction
  function automatic logic [7:0] get_f(input bit w32);
    return w32 ? if32.f_out : if16.f_out;
  endfunction

  // Issues one op, scrambles the inputs right after the start edge, and waits (bounded) for done.
  task automatic run_op(input bit w32, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [7:0] f, output logic [31:0] q, output logic [7:0] fo,
                        output int lat, output int held_bad, output logic busy0);
    logic [31:0] q_prev;
    @(negedge clk);
    drive(w32, 1'b1, op, a, b, f);
    q_prev = get_q(w32);
    @(posedge clk); #1;
    drive(w32, 1'b0, ~op, ~a, ~b, ~f);
    busy0    = get_busy(w32);
    lat      = 0;
    held_bad = 0;
    while (!get_done(w32) && lat < 20) begin
      if (get_q(w32) !== q_prev) held_bad++;
      @(posedge clk); #1;
      lat++;
    end
    q  = get_q(w32);
    fo = get_f(w32);
  endtask

  initial begin
    logic [31:0] q;
    logic [7:0]  fo;
    int          lat;
    int          held_bad;
    logic        busy0;
    logic [9:0]  busy_bits;
    logic [9:0]  done_bits;
    int          dcount;

    vq.push_back(mk(0, 4'h0, 32'h0FFF, 32'h0001, 8'h00, 32'h1000, 8'h20)); // ADD, H from bit 11
    vq.push_back(mk(0, 4'h2, 32'h0000, 32'h0001, 8'h0F, 32'hFFFF, 8'h7F)); // SUB underflow
    vq.push_back(mk(0, 4'h1, 32'hFFFF, 32'h0000, 8'h10, 32'h0000, 8'hB0)); // ADC wrap to zero
    vq.push_back(mk(0, 4'hB, 32'h0001, 32'h0000, 8'h10, 32'h8000, 8'h10)); // RR
    vq.push_back(mk(0, 4'hE, 32'h0001, 32'h0000, 8'h00, 32'h0000, 8'h90)); // SRL
    vq.push_back(mk(0, 4'h8, 32'h8000, 32'h0000, 8'h00, 32'h0001, 8'h10)); // RLC
    vq.push_back(mk(0, 4'h3, 32'h1000, 32'h0000, 8'h10, 32'h0FFF, 8'h60)); // SBC
    vq.push_back(mk(0, 4'h4, 32'hFF00, 32'h0FF0, 8'h05, 32'h0F00, 8'h25)); // AND
    vq.push_back(mk(0, 4'h5, 32'h1234, 32'h1234, 8'hFF, 32'h0000, 8'h8F)); // XOR to zero
    vq.push_back(mk(0, 4'h6, 32'h00F0, 32'h0F00, 8'h00, 32'h0FF0, 8'h00)); // OR
    vq.push_back(mk(0, 4'h7, 32'h1234, 32'h2345, 8'h00, 32'h1234, 8'h70)); // CP a<b
    vq.push_back(mk(0, 4'hC, 32'h4001, 32'h0000, 8'h00, 32'h8002, 8'h00)); // SLA
    vq.push_back(mk(0, 4'hD, 32'h8002, 32'h0000, 8'h00, 32'hC001, 8'h00)); // SRA
    vq.push_back(mk(0, 4'hA, 32'h8000, 32'h0000, 8'h00, 32'h0000, 8'h90)); // RL
    vq.push_back(mk(0, 4'h9, 32'h0001, 32'h0000, 8'h00, 32'h8000, 8'h10)); // RRC
    vq.push_back(mk(0, 4'hF, 32'hABCD, 32'h1111, 8'h5A, 32'hABCD, 8'h5A)); // NOP
    vq.push_back(mk(0, 4'h0, 32'h00FF, 32'h0001, 8'h00, 32'h0100, 8'h00)); // inter-slice carry
    vq.push_back(mk(0, 4'h3, 32'h0100, 32'h0000, 8'h10, 32'h00FF, 8'h40)); // inter-slice borrow
    vq.push_back(mk(1, 4'h7, 32'h12345678, 32'h12345678, 8'h00, 32'h12345678, 8'hC0));
    vq.push_back(mk(1, 4'h4, 32'hF0F0F0F0, 32'h0F0F0F0F, 8'h00, 32'h00000000, 8'hA0));
    vq.push_back(mk(1, 4'h0, 32'hFFFFFFFF, 32'h00000001, 8'h00, 32'h00000000, 8'hB0));
    vq.push_back(mk(1, 4'hE, 32'h80000000, 32'h00000000, 8'h00, 32'h40000000, 8'h00));

    reset = 1'b1;
    drive(0, 1'b0, 4'h0, 32'h0, 32'h0, 8'h0);
    drive(1, 1'b0, 4'h0, 32'h0, 32'h0, 8'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst16 busy", 64'(if16.busy), 64'd0);
    chk("rst16 done", 64'(if16.done), 64'd0);
    chk("rst16 q", 64'(if16.q), 64'd0);
    chk("rst16 f_out", 64'(if16.f_out), 64'd0);
    chk("rst32 busy", 64'(if32.busy), 64'd0);
    chk("rst32 done", 64'(if32.done), 64'd0);
    chk("rst32 q", 64'(if32.q), 64'd0);
    chk("rst32 f_out", 64'(if32.f_out), 64'd0);
    reset = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      run_op(vq[i].w32, vq[i].op, vq[i].a, vq[i].b, vq[i].f, q, fo, lat, held_bad, busy0);
      chk($sformatf("v%0d q", i), 64'(q), 64'(vq[i].q));
      chk($sformatf("v%0d f_out", i), 64'(fo), 64'(vq[i].fo));
      chk($sformatf("v%0d latency", i), 64'(lat), vq[i].w32 ? 64'd4 : 64'd2);
      chk($sformatf("v%0d busy_at_start", i), 64'(busy0), 64'd1);
      chk($sformatf("v%0d q_held", i), 64'(held_bad), 64'd0);
    end

    // start held for five edges: accepted at E0 and again in the done cycle (E3)
    @(negedge clk);
    drive(0, 1'b1, 4'h0, 32'h1, 32'h1, 8'h00);
    busy_bits = '0;
    done_bits = '0;
    for (int e = 0; e < 10; e++) begin
      @(posedge clk); #1;
      busy_bits[e] = if16.busy;
      done_bits[e] = if16.done;
      if (e == 4) drive(0, 1'b0, 4'h0, 32'h1, 32'h1, 8'h00);
    end
    chk("hold busy pattern", 64'(busy_bits), 64'h01B);
    chk("hold done pattern", 64'(done_bits), 64'h024);
    chk("hold q", 64'(if16.q), 64'h2);
    chk("hold f_out", 64'(if16.f_out), 64'h0);

    // reset on the edge after start aborts the op
    @(negedge clk);
    drive(0, 1'b1, 4'h0, 32'h3, 32'h4, 8'h00);
    @(posedge clk); #1;
    drive(0, 1'b0, 4'h0, 32'h0, 32'h0, 8'h00);
    chk("abort busy before reset", 64'(if16.busy), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort busy", 64'(if16.busy), 64'd0);
    chk("abort done", 64'(if16.done), 64'd0);
    chk("abort q", 64'(if16.q), 64'd0);
    chk("abort f_out", 64'(if16.f_out), 64'd0);
    dcount = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (if16.done) dcount++;
    end
    chk("abort no done", 64'(dcount), 64'd0);

    run_op(0, 4'h0, 32'h3, 32'h4, 8'h00, q, fo, lat, held_bad, busy0);
    chk("recover q", 64'(q), 64'h7);
    chk("recover f_out", 64'(fo), 64'h0);
    chk("recover latency", 64'(lat), 64'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
